// File: rtl/axi_lite_mem_slave_pkg.sv
// ============================================================================
// Module      : axi_lite_mem_slave_pkg
// Description : Shared AXI4-Lite channel types, response codes and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_lite_mem_slave_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 8;
    localparam int STRB_WIDTH = 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;
    typedef logic [1:0]            resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_DECERR = 2'b11;

    localparam int DEFAULT_MEM_DEPTH = 1024;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Full-width compare: addresses at or above the depth decode as errors, never alias.
    function automatic logic addr_in_range(input addr_t addr, input int unsigned depth);
        return 32'(addr) < depth;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_mem_slave_if.sv
// ============================================================================
// Module      : axi_lite_mem_slave_if
// Description : AXI4-Lite AW/W/B/AR/R channel bundle with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_lite_mem_slave_if
    import axi_lite_mem_slave_pkg::*;
();

    addr_t awaddr;
    logic  awvalid;
    logic  awready;
    data_t wdata;
    strb_t wstrb;
    logic  wvalid;
    logic  wready;
    resp_t bresp;
    logic  bvalid;
    logic  bready;
    addr_t araddr;
    logic  arvalid;
    logic  arready;
    data_t rdata;
    resp_t rresp;
    logic  rvalid;
    logic  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

`default_nettype wire

// File: rtl/axi_lite_mem_array.sv
// ============================================================================
// Module      : axi_lite_mem_array
// Description : Byte-wide storage, one sync write and one sync read port;
//               a same-edge read returns the pre-write contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_mem_array
    import axi_lite_mem_slave_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  data_t                wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output data_t                rdata
);

    data_t r_mem [MEM_DEPTH];
    data_t r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/axi_lite_mem_slave.sv
// ============================================================================
// Module      : axi_lite_mem_slave
// Description : AXI4-Lite slave terminating one port into a byte memory, with
//               independent write (AW+W->B) and read (AR->R) state machines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_mem_slave
    import axi_lite_mem_slave_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    axi_lite_mem_slave_if.slave  bus
);

    localparam int ADDR_BITS = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Holds every ready low through the reset edge and releases them together.
    logic r_alive;

    wr_state_t r_wr_state;
    wr_state_t w_wr_state_nxt;
    logic      r_aw_done;
    logic      r_w_done;
    addr_t     r_awaddr;
    data_t     r_wdata;
    strb_t     r_wstrb;
    resp_t     r_bresp;

    logic      w_aw_hs;
    logic      w_w_hs;
    logic      w_b_hs;
    logic      w_commit;
    addr_t     w_wr_addr;
    data_t     w_wr_data;
    strb_t     w_wr_strb;
    logic      w_wr_okay;
    logic      w_mem_we;

    rd_state_t r_rd_state;
    rd_state_t w_rd_state_nxt;
    logic      r_rd_okay;
    resp_t     r_rresp;
    logic      w_ar_hs;
    logic      w_r_hs;
    logic      w_rd_okay;
    logic      w_mem_re;
    data_t     w_mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    assign w_aw_hs   = bus.awvalid & bus.awready;
    assign w_w_hs    = bus.wvalid  & bus.wready;
    assign w_b_hs    = bus.bvalid  & bus.bready;
    assign w_wr_addr = r_aw_done ? r_awaddr : bus.awaddr;
    assign w_wr_data = r_w_done  ? r_wdata  : bus.wdata;
    assign w_wr_strb = r_w_done  ? r_wstrb  : bus.wstrb;
    assign w_wr_okay = addr_in_range(w_wr_addr, MEM_DEPTH);
    assign w_commit  = (r_wr_state == W_IDLE) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    // A half landing on the reset edge must not reach the memory.
    assign w_mem_we  = w_commit && w_wr_okay && w_wr_strb[0] && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= W_IDLE;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            if (w_b_hs) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
            if (w_commit) begin
                r_bresp <= w_wr_okay ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_awaddr <= bus.awaddr;
        end
        if (w_w_hs) begin
            r_wdata <= bus.wdata;
            r_wstrb <= bus.wstrb;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_commit) w_wr_state_nxt = W_RESP;
            W_RESP:  if (w_b_hs)   w_wr_state_nxt = W_IDLE;
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        bus.awready = r_alive && (r_wr_state == W_IDLE) && !r_aw_done;
        bus.wready  = r_alive && (r_wr_state == W_IDLE) && !r_w_done;
        bus.bvalid  = (r_wr_state == W_RESP);
        bus.bresp   = r_bresp;
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    assign w_ar_hs   = bus.arvalid & bus.arready;
    assign w_r_hs    = bus.rvalid  & bus.rready;
    assign w_rd_okay = addr_in_range(bus.araddr, MEM_DEPTH);
    assign w_mem_re  = w_ar_hs && w_rd_okay && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= R_IDLE;
            r_rd_okay  <= 1'b0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (w_ar_hs) begin
                r_rd_okay <= w_rd_okay;
                r_rresp   <= w_rd_okay ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_state_nxt = R_DATA;
            R_DATA:  if (w_r_hs)  w_rd_state_nxt = R_IDLE;
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    // The array output only changes on an accepted read, so rdata holds while stalled.
    always_comb begin
        bus.arready = r_alive && (r_rd_state == R_IDLE);
        bus.rvalid  = (r_rd_state == R_DATA);
        bus.rresp   = r_rresp;
        bus.rdata   = r_rd_okay ? w_mem_rdata : '0;
    end

    axi_lite_mem_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (w_wr_addr[ADDR_BITS-1:0]),
        .wdata (w_wr_data),
        .re    (w_mem_re),
        .raddr (bus.araddr[ADDR_BITS-1:0]),
        .rdata (w_mem_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_mem_slave.sv
// ============================================================================
// Module      : tb_axi_lite_mem_slave
// Description : Directed self-checking bench for axi_lite_mem_slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_mem_slave;
    import axi_lite_mem_slave_pkg::*;

    logic clk;
    logic reset;
    int   n_asserts;
    int   n_fail;

    axi_lite_mem_slave_if bus ();

    axi_lite_mem_slave #(.MEM_DEPTH(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input addr_t a, input data_t d, input strb_t s,
                             output logic v, output resp_t r);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        v = bus.bvalid; r = bus.bresp;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input addr_t a, output logic v, output data_t d, output resp_t r);
        bus.araddr = a; bus.arvalid = 1'b1;
        tick();
        v = bus.rvalid; d = bus.rdata; r = bus.rresp;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_asserts += 8;
        if (bus.awready !== 1'b0) begin $display("FAIL rst_awready: got %b want 0", bus.awready); n_fail++; end
        if (bus.wready  !== 1'b0) begin $display("FAIL rst_wready: got %b want 0", bus.wready); n_fail++; end
        if (bus.arready !== 1'b0) begin $display("FAIL rst_arready: got %b want 0", bus.arready); n_fail++; end
        if (bus.bvalid  !== 1'b0) begin $display("FAIL rst_bvalid: got %b want 0", bus.bvalid); n_fail++; end
        if (bus.rvalid  !== 1'b0) begin $display("FAIL rst_rvalid: got %b want 0", bus.rvalid); n_fail++; end
        if (bus.bresp   !== 2'b00) begin $display("FAIL rst_bresp: got %b want 00", bus.bresp); n_fail++; end
        if (bus.rresp   !== 2'b00) begin $display("FAIL rst_rresp: got %b want 00", bus.rresp); n_fail++; end
        if (bus.rdata   !== 8'h00) begin $display("FAIL rst_rdata: got %h want 00", bus.rdata); n_fail++; end
        reset = 1'b0;
        tick();
        n_asserts += 3;
        if (bus.awready !== 1'b1) begin $display("FAIL post_rst_awready: got %b want 1", bus.awready); n_fail++; end
        if (bus.wready  !== 1'b1) begin $display("FAIL post_rst_wready: got %b want 1", bus.wready); n_fail++; end
        if (bus.arready !== 1'b1) begin $display("FAIL post_rst_arready: got %b want 1", bus.arready); n_fail++; end
    endtask

    task automatic test_basic();
        logic v; data_t d; resp_t r;
        bus.awaddr = 12'h005; bus.wdata = 8'hA5; bus.wstrb = 1'b1;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        n_asserts += 4;
        if (bus.bvalid  !== 1'b1)  begin $display("FAIL basic_bvalid: got %b want 1", bus.bvalid); n_fail++; end
        if (bus.bresp   !== 2'b00) begin $display("FAIL basic_bresp: got %b want 00", bus.bresp); n_fail++; end
        if (bus.awready !== 1'b0)  begin $display("FAIL basic_awready_busy: got %b want 0", bus.awready); n_fail++; end
        if (bus.wready  !== 1'b0)  begin $display("FAIL basic_wready_busy: got %b want 0", bus.wready); n_fail++; end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        n_asserts += 3;
        if (bus.bvalid  !== 1'b0) begin $display("FAIL basic_bvalid_clr: got %b want 0", bus.bvalid); n_fail++; end
        if (bus.awready !== 1'b1) begin $display("FAIL basic_awready_rel: got %b want 1", bus.awready); n_fail++; end
        if (bus.wready  !== 1'b1) begin $display("FAIL basic_wready_rel: got %b want 1", bus.wready); n_fail++; end
        axi_read(12'h005, v, d, r);
        n_asserts += 3;
        if (v !== 1'b1)  begin $display("FAIL basic_rvalid: got %b want 1", v); n_fail++; end
        if (d !== 8'hA5) begin $display("FAIL basic_rdata: got %h want a5", d); n_fail++; end
        if (r !== 2'b00) begin $display("FAIL basic_rresp: got %b want 00", r); n_fail++; end
    endtask

    task automatic test_w_before_aw();
        logic v; data_t d; resp_t r;
        bus.wdata = 8'h3C; bus.wstrb = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        n_asserts += 3;
        if (bus.wready  !== 1'b0) begin $display("FAIL wfirst_wready: got %b want 0", bus.wready); n_fail++; end
        if (bus.awready !== 1'b1) begin $display("FAIL wfirst_awready: got %b want 1", bus.awready); n_fail++; end
        if (bus.bvalid  !== 1'b0) begin $display("FAIL wfirst_bvalid_early: got %b want 0", bus.bvalid); n_fail++; end
        tick(); tick();
        n_asserts += 1;
        if (bus.bvalid !== 1'b0) begin $display("FAIL wfirst_bvalid_wait: got %b want 0", bus.bvalid); n_fail++; end
        bus.awaddr = 12'h010; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        n_asserts += 2;
        if (bus.bvalid !== 1'b1)  begin $display("FAIL wfirst_bvalid: got %b want 1", bus.bvalid); n_fail++; end
        if (bus.bresp  !== 2'b00) begin $display("FAIL wfirst_bresp: got %b want 00", bus.bresp); n_fail++; end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        axi_read(12'h010, v, d, r);
        n_asserts += 2;
        if (d !== 8'h3C) begin $display("FAIL wfirst_rdata: got %h want 3c", d); n_fail++; end
        if (r !== 2'b00) begin $display("FAIL wfirst_rresp: got %b want 00", r); n_fail++; end
    endtask

    task automatic test_decode();
        logic v; data_t d; resp_t r;
        axi_write(12'h000, 8'h5A, 1'b1, v, r);
        axi_write(12'h400, 8'hFF, 1'b1, v, r);
        n_asserts += 2;
        if (v !== 1'b1)  begin $display("FAIL dec_wr_bvalid: got %b want 1", v); n_fail++; end
        if (r !== 2'b11) begin $display("FAIL dec_wr_bresp: got %b want 11", r); n_fail++; end
        axi_read(12'h000, v, d, r);
        n_asserts += 1;
        if (d !== 8'h5A) begin $display("FAIL dec_no_alias: got %h want 5a", d); n_fail++; end
        axi_read(12'h400, v, d, r);
        n_asserts += 2;
        if (r !== 2'b11) begin $display("FAIL dec_rd400_rresp: got %b want 11", r); n_fail++; end
        if (d !== 8'h00) begin $display("FAIL dec_rd400_rdata: got %h want 00", d); n_fail++; end
        axi_read(12'h7FF, v, d, r);
        n_asserts += 3;
        if (v !== 1'b1)  begin $display("FAIL dec_rd7ff_rvalid: got %b want 1", v); n_fail++; end
        if (r !== 2'b11) begin $display("FAIL dec_rd7ff_rresp: got %b want 11", r); n_fail++; end
        if (d !== 8'h00) begin $display("FAIL dec_rd7ff_rdata: got %h want 00", d); n_fail++; end
        axi_write(12'h3FF, 8'hC3, 1'b1, v, r);
        n_asserts += 1;
        if (r !== 2'b00) begin $display("FAIL dec_wr3ff_bresp: got %b want 00", r); n_fail++; end
        axi_read(12'h3FF, v, d, r);
        n_asserts += 2;
        if (r !== 2'b00) begin $display("FAIL dec_rd3ff_rresp: got %b want 00", r); n_fail++; end
        if (d !== 8'hC3) begin $display("FAIL dec_rd3ff_rdata: got %h want c3", d); n_fail++; end
    endtask

    task automatic test_backpressure();
        logic v; data_t d; resp_t r;
        bus.awaddr = 12'h030; bus.wdata = 8'h77; bus.wstrb = 1'b1;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 12'h005; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_asserts += 7;
            if (bus.bvalid  !== 1'b1)  begin $display("FAIL bp_bvalid[%0d]: got %b want 1", i, bus.bvalid); n_fail++; end
            if (bus.bresp   !== 2'b00) begin $display("FAIL bp_bresp[%0d]: got %b want 00", i, bus.bresp); n_fail++; end
            if (bus.rvalid  !== 1'b1)  begin $display("FAIL bp_rvalid[%0d]: got %b want 1", i, bus.rvalid); n_fail++; end
            if (bus.rdata   !== 8'hA5) begin $display("FAIL bp_rdata[%0d]: got %h want a5", i, bus.rdata); n_fail++; end
            if (bus.awready !== 1'b0)  begin $display("FAIL bp_awready[%0d]: got %b want 0", i, bus.awready); n_fail++; end
            if (bus.wready  !== 1'b0)  begin $display("FAIL bp_wready[%0d]: got %b want 0", i, bus.wready); n_fail++; end
            if (bus.arready !== 1'b0)  begin $display("FAIL bp_arready[%0d]: got %b want 0", i, bus.arready); n_fail++; end
            tick();
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        n_asserts += 5;
        if (bus.bvalid  !== 1'b0) begin $display("FAIL bp_bvalid_rel: got %b want 0", bus.bvalid); n_fail++; end
        if (bus.rvalid  !== 1'b0) begin $display("FAIL bp_rvalid_rel: got %b want 0", bus.rvalid); n_fail++; end
        if (bus.awready !== 1'b1) begin $display("FAIL bp_awready_rel: got %b want 1", bus.awready); n_fail++; end
        if (bus.wready  !== 1'b1) begin $display("FAIL bp_wready_rel: got %b want 1", bus.wready); n_fail++; end
        if (bus.arready !== 1'b1) begin $display("FAIL bp_arready_rel: got %b want 1", bus.arready); n_fail++; end
        axi_read(12'h030, v, d, r);
        n_asserts += 1;
        if (d !== 8'h77) begin $display("FAIL bp_rd030: got %h want 77", d); n_fail++; end
    endtask

    task automatic test_collision();
        logic v; data_t d; resp_t r;
        axi_write(12'h020, 8'h11, 1'b1, v, r);
        bus.awaddr = 12'h020; bus.wdata = 8'h22; bus.wstrb = 1'b1;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 12'h020; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        n_asserts += 3;
        if (bus.rvalid !== 1'b1)  begin $display("FAIL col_rvalid: got %b want 1", bus.rvalid); n_fail++; end
        if (bus.rdata  !== 8'h11) begin $display("FAIL col_old_data: got %h want 11", bus.rdata); n_fail++; end
        if (bus.bvalid !== 1'b1)  begin $display("FAIL col_bvalid: got %b want 1", bus.bvalid); n_fail++; end
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        axi_read(12'h020, v, d, r);
        n_asserts += 1;
        if (d !== 8'h22) begin $display("FAIL col_new_data: got %h want 22", d); n_fail++; end
        axi_write(12'h020, 8'h99, 1'b0, v, r);
        n_asserts += 2;
        if (v !== 1'b1)  begin $display("FAIL strb0_bvalid: got %b want 1", v); n_fail++; end
        if (r !== 2'b00) begin $display("FAIL strb0_bresp: got %b want 00", r); n_fail++; end
        axi_read(12'h020, v, d, r);
        n_asserts += 1;
        if (d !== 8'h22) begin $display("FAIL strb0_rdata: got %h want 22", d); n_fail++; end
    endtask

    task automatic test_reset_mid();
        logic v; data_t d; resp_t r;
        axi_write(12'h050, 8'h12, 1'b1, v, r);
        bus.awaddr = 12'h050; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        n_asserts += 2;
        if (bus.awready !== 1'b0) begin $display("FAIL mid_aw_captured: got %b want 0", bus.awready); n_fail++; end
        if (bus.wready  !== 1'b1) begin $display("FAIL mid_w_open: got %b want 1", bus.wready); n_fail++; end
        bus.wdata = 8'hEE; bus.wstrb = 1'b1; bus.wvalid = 1'b1;
        reset = 1'b1;
        tick();
        n_asserts += 5;
        if (bus.awready !== 1'b0) begin $display("FAIL mid_rst_awready: got %b want 0", bus.awready); n_fail++; end
        if (bus.wready  !== 1'b0) begin $display("FAIL mid_rst_wready: got %b want 0", bus.wready); n_fail++; end
        if (bus.arready !== 1'b0) begin $display("FAIL mid_rst_arready: got %b want 0", bus.arready); n_fail++; end
        if (bus.bvalid  !== 1'b0) begin $display("FAIL mid_rst_bvalid: got %b want 0", bus.bvalid); n_fail++; end
        if (bus.rvalid  !== 1'b0) begin $display("FAIL mid_rst_rvalid: got %b want 0", bus.rvalid); n_fail++; end
        bus.wvalid = 1'b0;
        reset = 1'b0;
        tick();
        n_asserts += 3;
        if (bus.awready !== 1'b1) begin $display("FAIL mid_post_awready: got %b want 1", bus.awready); n_fail++; end
        if (bus.wready  !== 1'b1) begin $display("FAIL mid_post_wready: got %b want 1", bus.wready); n_fail++; end
        if (bus.arready !== 1'b1) begin $display("FAIL mid_post_arready: got %b want 1", bus.arready); n_fail++; end
        for (int i = 0; i < 4; i++) begin
            n_asserts += 1;
            if (bus.bvalid !== 1'b0) begin $display("FAIL mid_no_bresp[%0d]: got %b want 0", i, bus.bvalid); n_fail++; end
            tick();
        end
        axi_read(12'h050, v, d, r);
        n_asserts += 1;
        if (d !== 8'h12) begin $display("FAIL mid_mem_kept: got %h want 12", d); n_fail++; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        reset       = 1'b0;
        bus.awaddr  = '0; bus.awvalid = 1'b0;
        bus.wdata   = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0; bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        test_reset();
        test_basic();
        test_w_before_aw();
        test_decode();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
AXI4-Lite slave endpoint that sits directly downstream of the interconnect and terminates one slave port. It contains a byte-wide memory and serves read and write transactions with independent read and write state machines. It uses the shared channel widths and response codes: ADDR_WIDTH=12, DATA_WIDTH=8, STRB_WIDTH=1, and RESP_OKAY/RESP_DECERR.

Parameters:
MEM_DEPTH, 1024, number of byte locations; legal addresses are 0..MEM_DEPTH-1, and MEM_DEPTH must be ≤ 2**ADDR_WIDTH.

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
awaddr  in  12  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  8  write data
wstrb  in  1  write strobe
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  12  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  8  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready

Behaviour:
- Handshake: a transfer occurs on any edge where valid and ready are both 1. Once rvalid or bvalid is asserted, it stays high and its payload stays stable until the matching ready is seen. Ready never depends combinationally on valid.
- Reset: while reset=1 at an edge, the outputs awready, wready, arready, bvalid and rvalid are all 0, and bresp, rresp and rdata are 0. Both FSMs go to IDLE and the capture flags clear. Memory contents are not reset.
- On the first cycle after reset deasserts, awready=wready=arready=1.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, the AW and W channels are captured independently in any order. Each gets a captured flag, and that channel's ready drops to 0 once its flag is set.
  - On the edge where the second of the two is captured (or both on the same edge), the write commits. If the address is < MEM_DEPTH and wstrb=1, mem[addr] is written.
  - On that same edge the FSM moves to W_RESP with bvalid=1. bvalid is therefore high one cycle after the last handshake.
  - In W_RESP, awready=wready=0. bresp=RESP_OKAY if addr < MEM_DEPTH, else RESP_DECERR (the write is dropped).
  - wstrb=0 gives no memory update and RESP_OKAY.
  - On the bvalid&bready edge: return to W_IDLE, clear both flags, and set awready=wready=1 for the next cycle. There is no back-to-back combinational acceptance.
- Read FSM states: R_IDLE, R_DATA.
  - In R_IDLE, arready=1. On the AR handshake edge, rdata is registered from the memory as it stood before that edge, the FSM moves to R_DATA, and rvalid=1 on the next cycle (1-cycle latency).
  - rresp=RESP_OKAY if addr < MEM_DEPTH, else RESP_DECERR with rdata=0.
  - In R_DATA, arready=0. On the rvalid&rready edge, return to R_IDLE.
- Read and write are fully independent and may proceed in the same cycle.
- Same-address collision: if a write commit and an AR handshake occur on the same edge, the read returns the OLD data, and the write is visible to any later read.
- Address decode: the full 12-bit address is compared against MEM_DEPTH; there is no aliasing or wrap-around.
- Reset mid-transaction: any pending response is abandoned with no completion. Captured AW/W halves are discarded and not written.

Decomposition:
- Shared package (the existing AXI-Lite package) gains:
  - write-FSM and read-FSM state enums
  - default MEM_DEPTH constant
  - the existing addr_t/data_t/strb_t/resp_t and RESP_* constants are reused
- One sub-module, axi_lite_mem_array:
  - MEM_DEPTH x 8 storage
  - one synchronous write port and one synchronous read port, read-old-on-collision
  - no reset

Test Plan:
- Write 0x005←0xA5 with AW and W in the same cycle, then bready=1 → bvalid one cycle after handshake, bresp=00. Then read 0x005 → rvalid one cycle after AR handshake, rdata=0xA5, rresp=00.
- W arrives 3 cycles before AW (addr 0x010, data 0x3C) → wready=0 after W capture, bvalid one cycle after AW handshake. A read of 0x010 returns 0x3C.
- Write to 0x400 (= MEM_DEPTH) data 0xFF → bresp=11 and memory unchanged. Read 0x7FF → rresp=11, rdata=0x00.
- Backpressure: hold bready=0 and rready=0 for 5 cycles → bvalid/rvalid and bresp/rdata stay stable, and awready/wready/arready stay 0 until release.
- Collision: mem[0x020]=0x11; write 0x22 and AR to 0x020 commit on the same edge → rdata=0x11; a following read returns 0x22. A write with wstrb=0 leaves 0x22 and returns bresp=00.
- Assert reset for 1 cycle after AW is captured but before W → awready, wready, arready, bvalid and rvalid are all 0 during reset. Afterwards all readies are 1, no B response is ever issued, and the memory is unchanged.
